// File: rtl/led_scan_sequencer.sv
// led_scan_sequencer
// Drives the switch/enable pins of a registered 3-to-8 active-low LED decoder.
// Mode commands arrive over a valid/ready handshake. The block then sequences
// the lit LED index autonomously: off, hold, walk (0..7 repeating) or bounce
// (0..7..0 triangle). enable is only ever 3'b100 (lit) or 3'b000 (dark).
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high. cmd_ready is combinational from registered state
// only and never depends on cmd_valid. The requester keeps cmd_valid,
// cmd_mode and cmd_idx stable until the transfer happens. cmd_valid without
// cmd_ready is ignored. While idle or holding, a command can be taken on any
// cycle. While walking or bouncing, a command can be taken only on the last
// cycle of a step, so every displayed index stays up for a whole step.

module led_scan_sequencer #(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_mode,
    input  logic [2:0] cmd_idx,
    output logic [2:0] switch,
    output logic [2:0] enable,
    output logic       wrap,
    output logic [2:0] state_dbg
);

    // Tick counter width: at least one bit, even when TICK_DIV is 1.
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

    localparam logic [2:0] EN_LIT  = 3'b100;
    localparam logic [2:0] EN_DARK = 3'b000;

    localparam logic [1:0] MODE_OFF    = 2'd0;
    localparam logic [1:0] MODE_HOLD   = 2'd1;
    localparam logic [1:0] MODE_WALK   = 2'd2;
    localparam logic [1:0] MODE_BOUNCE = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HOLD   = 3'd1,
        ST_WALK   = 3'd2,
        ST_BNC_UP = 3'd3,
        ST_BNC_DN = 3'd4
    } state_t;

    state_t        state;
    logic [TW-1:0] tick;
    logic          running;
    logic          step;
    logic          accept;

    // The step strobe marks the last cycle of each index while sequencing.
    always_comb begin
        running   = (state == ST_WALK) || (state == ST_BNC_UP) || (state == ST_BNC_DN);
        step      = running && (tick == TICK_MAX);
        cmd_ready = !running || step;
        accept    = cmd_valid && cmd_ready;
        state_dbg = state;
    end

    // Sequencer: command load, tick counting, index stepping and wrap pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            tick   <= '0;
            switch <= 3'd0;
            enable <= EN_DARK;
            wrap   <= 1'b0;
        end else begin
            // wrap is a single-cycle pulse; only a wrap event below re-asserts it.
            wrap <= 1'b0;
            if (accept) begin
                // A new command wins over any step falling on the same edge.
                tick <= '0;
                unique case (cmd_mode)
                    MODE_OFF: begin
                        state  <= ST_IDLE;
                        switch <= 3'd0;
                        enable <= EN_DARK;
                    end
                    MODE_HOLD: begin
                        state  <= ST_HOLD;
                        switch <= cmd_idx;
                        enable <= EN_LIT;
                    end
                    MODE_WALK: begin
                        state  <= ST_WALK;
                        switch <= cmd_idx;
                        enable <= EN_LIT;
                    end
                    MODE_BOUNCE: begin
                        // Starting at the top end means the first move is downward.
                        state  <= (cmd_idx == 3'd7) ? ST_BNC_DN : ST_BNC_UP;
                        switch <= cmd_idx;
                        enable <= EN_LIT;
                    end
                    default: begin
                        state  <= ST_IDLE;
                        switch <= 3'd0;
                        enable <= EN_DARK;
                    end
                endcase
            end else if (running) begin
                tick <= step ? '0 : tick + 1'b1;
                if (step) begin
                    unique case (state)
                        ST_WALK: begin
                            switch <= switch + 3'd1;
                            if (switch == 3'd7) begin
                                wrap <= 1'b1;
                            end
                        end
                        ST_BNC_UP: begin
                            switch <= switch + 3'd1;
                            if (switch == 3'd6) begin
                                state <= ST_BNC_DN;
                            end
                        end
                        ST_BNC_DN: begin
                            switch <= switch - 3'd1;
                            if (switch == 3'd1) begin
                                state <= ST_BNC_UP;
                                wrap  <= 1'b1;
                            end
                        end
                        default: begin
                            state <= state;
                        end
                    endcase
                end
            end else begin
                // Idle and hold keep the tick counter parked at zero.
                tick <= '0;
            end
        end
    end

endmodule

// File: tb/tb_led_scan_sequencer.sv
// tb_led_scan_sequencer
// Randomized and directed command sequences against a reference model that
// derives the expected LED index arithmetically from the active mode, the
// start index and the number of cycles since the command took effect.

module tb_led_scan_sequencer;

    localparam int TD = 4;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic [2:0] cmd_idx;
    logic [2:0] switch;
    logic [2:0] enable;
    logic       wrap;
    logic [2:0] state_dbg;

    int total;
    int bad;

    // Reference model state: active mode, start index, cycles since it took effect.
    int m_mode;
    int m_start;
    int m_n;

    led_scan_sequencer #(.TICK_DIV(TD)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_idx   (cmd_idx),
        .switch    (switch),
        .enable    (enable),
        .wrap      (wrap),
        .state_dbg (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs from the mode rules: walk is (start+k) mod 8; bounce is a
    // triangle wave of period 14 where position t shows t (t<=7) or 14-t.
    task automatic model_out(output int e_sw, output int e_en, output int e_wrap,
                             output int e_rdy);
        int k;
        int t;
        k      = m_n / TD;
        e_sw   = 0;
        e_en   = 0;
        e_wrap = 0;
        e_rdy  = 1;
        case (m_mode)
            1: begin
                e_sw = m_start;
                e_en = 4;
            end
            2, 3: begin
                if (m_mode == 2) begin
                    e_sw = (m_start + k) % 8;
                end else begin
                    t    = (m_start + k) % 14;
                    e_sw = (t <= 7) ? t : 14 - t;
                end
                e_en   = 4;
                e_wrap = (k > 0 && (m_n % TD) == 0 && e_sw == 0) ? 1 : 0;
                e_rdy  = ((m_n % TD) == TD - 1) ? 1 : 0;
            end
            default: ;
        endcase
    endtask

    // One clock: check outputs mid-cycle, then advance the model across the edge.
    task automatic step_cycle(output bit acc);
        int e_sw, e_en, e_wrap, e_rdy;
        @(negedge clk);
        model_out(e_sw, e_en, e_wrap, e_rdy);
        chk("switch", 32'(switch), 32'(e_sw));
        chk("enable", 32'(enable), 32'(e_en));
        chk("wrap", 32'(wrap), 32'(e_wrap));
        chk("cmd_ready", 32'(cmd_ready), 32'(e_rdy));
        acc = cmd_valid && (e_rdy == 1);
        @(posedge clk);
        if (acc) begin
            m_mode  = int'(cmd_mode);
            m_start = int'(cmd_idx);
            m_n     = 0;
        end else begin
            m_n++;
        end
        #1;
    endtask

    task automatic run_cycles(input int n);
        bit acc;
        for (int i = 0; i < n; i++) begin
            step_cycle(acc);
        end
    endtask

    // Present a command and hold it until the model says it was taken.
    task automatic send_cmd(input int mode, input int idx, output int waited);
        bit acc;
        cmd_valid = 1'b1;
        cmd_mode  = 2'(mode);
        cmd_idx   = 3'(idx);
        acc       = 1'b0;
        waited    = 0;
        while (!acc && waited < 300) begin
            step_cycle(acc);
            waited++;
        end
        if (!acc) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end
        cmd_valid = 1'b0;
    endtask

    int w;
    int wraps;

    initial begin
        total     = 0;
        bad       = 0;
        m_mode    = 0;
        m_start   = 0;
        m_n       = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_mode  = 2'd0;
        cmd_idx   = 3'd0;
        repeat (3) @(negedge clk);
        chk("reset_switch", 32'(switch), 32'd0);
        chk("reset_enable", 32'(enable), 32'd0);
        chk("reset_ready", 32'(cmd_ready), 32'd1);
        rst = 1'b0;
        run_cycles(3);

        // Hold at index 5 for 40 cycles.
        send_cmd(1, 5, w);
        run_cycles(40);
        chk("hold_switch", 32'(switch), 32'd5);
        chk("hold_enable", 32'(enable), 32'd4);

        // Walk from 6: 6,7,0,1 each for TD cycles, wrap with the first 0.
        send_cmd(2, 6, w);
        run_cycles(3 * TD);

        // Command held mid-step while walking: only taken on the step's last cycle.
        run_cycles(1);
        send_cmd(1, 2, w);
        chk("midstep_wait", 32'(w), 32'(TD - 1));
        run_cycles(2);

        // Bounce from 6 through a full period; exactly one wrap (at the first 0).
        send_cmd(3, 6, w);
        wraps = 0;
        for (int i = 0; i < 14 * TD; i++) begin
            bit acc;
            step_cycle(acc);
            if (wrap) wraps++;
        end
        chk("bounce_wraps", 32'(wraps), 32'd1);

        // Off during bounce: taken at a step boundary, LEDs dark next clock.
        send_cmd(0, 3, w);
        run_cycles(6);
        chk("off_enable", 32'(enable), 32'd0);

        // Bounce starting at 7 goes down first; bounce from 0 goes up with no wrap.
        send_cmd(3, 7, w);
        run_cycles(3 * TD);
        send_cmd(3, 0, w);
        run_cycles(3 * TD);

        // Asynchronous reset mid-walk takes effect without a clock edge.
        send_cmd(2, 1, w);
        run_cycles(TD + 2);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_switch", 32'(switch), 32'd0);
        chk("rst_enable", 32'(enable), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst     = 1'b0;
        m_mode  = 0;
        m_start = 0;
        m_n     = 0;
        run_cycles(2);

        // Random command mix.
        for (int r = 0; r < 40; r++) begin
            send_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), w);
            run_cycles(int'($urandom_range(1, 70)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
